// File: rtl/serial_mag_comparator_if.sv
// Start/busy/done handshake plus operand and result bus for the serial magnitude comparator.
// The controller drives the master side; the comparator takes the slave side.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             EQ;
  logic             GT;

  modport master (
    output start, A, B,
    input  busy, done, EQ, GT
  );

  modport slave (
    input  start, A, B,
    output busy, done, EQ, GT
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Compares two unsigned WIDTH-bit operands one 2-bit digit per clock, MSB digit first.
// It uses an EQ/GT cascade and publishes a registered result with a done pulse.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_mag_comparator_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("serial_mag_comparator: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_eq_c;
  logic             r_gt_c;
  logic             r_eq;
  logic             r_gt;
  logic [1:0]       w_dig_a;
  logic [1:0]       w_dig_b;
  logic             w_slice_eq;
  logic             w_slice_gt;
  logic             w_load;
  logic             w_last;

  // 2-bit cascade slice: a decided GT/LT is frozen once eq_c drops.
  assign w_dig_a    = r_a[{r_cnt, 1'b0} +: 2];
  assign w_dig_b    = r_b[{r_cnt, 1'b0} +: 2];
  assign w_slice_eq = r_eq_c & (w_dig_a == w_dig_b);
  assign w_slice_gt = r_gt_c | (r_eq_c & (w_dig_a > w_dig_b));
  assign w_last     = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_eq_c <= 1'b1;
      r_gt_c <= 1'b0;
      r_cnt  <= '0;
      r_eq   <= 1'b0;
      r_gt   <= 1'b0;
    end else if (w_load) begin
      r_eq_c <= 1'b1;
      r_gt_c <= 1'b0;
      r_cnt  <= CW'(N - 1);
    end else if (r_state == S_RUN) begin
      r_eq_c <= w_slice_eq;
      r_gt_c <= w_slice_gt;
      if (w_last) begin
        r_eq <= w_slice_eq;
        r_gt <= w_slice_gt;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Operands carry no reset; they are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (rst_n && w_load) begin
      r_a <= bus.A;
      r_b <= bus.B;
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.EQ   = r_eq;
  assign bus.GT   = r_gt;
endmodule
